vga_fb_scanout: RTL and testbench
=================================

Name: vga_fb_scanout

Overview:
Parametrised VGA scan-out engine. Combines timing generation, framebuffer address generation and pixel unpacking in one block. Generates sync and blanking from configurable timing. Fetches packed pixels from a single-port synchronous framebuffer RAM with configurable read latency. Replicates each source pixel 2^SCALE_LOG2 times in x and y, and drives RGB332 to the pads.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SCALE_LOG2, 2, log2 of pixel replication factor; source frame is (H_ACTIVE>>S) x (V_ACTIVE>>S)
WORD_W, 16, RAM word width; must be a multiple of 8 (PPW = WORD_W/8 pixels per word, power of 2)
ADDR_W, 14, RAM address width
MEM_LAT, 1, RAM read latency in clocks (>=1)
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan-out enable; sampled at frame start
base_addr  in  ADDR_W  framebuffer word base; sampled at frame start
mem_addr  out  ADDR_W  RAM read address
mem_rd_en  out  1  RAM read strobe
mem_rdata  in  WORD_W  RAM read data, valid MEM_LAT clocks after mem_addr
vga_red  out  3  red, pixel bits [7:5]
vga_green  out  3  green, pixel bits [4:2]
vga_blue  out  2  blue, pixel bits [1:0]
h_sync  out  1  horizontal sync
v_sync  out  1  vertical sync
active  out  1  high while the displayed pixel is visible
frame_start  out  1  one-cycle pulse coincident with output of pixel (0,0)

Behaviour:
- Reset (async, rst_n=0): h_cnt=v_cnt=0. frame_en=0, lat_base=0. mem_addr=0, mem_rd_en=0. RGB=0, active=0, frame_start=0. h_sync=v_sync=~SYNC_POL. All pipeline stages cleared.
- Counters: h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of H params. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
- Stage-0 decode:
  - vis = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- Frame start (h_cnt=0, v_cnt=0): frame_en <= enable, lat_base <= base_addr. Changes to enable or base_addr mid-frame take effect only on the next frame.
- Address generation (no multiplier):
  - row_base resets to lat_base at frame start.
  - row_base adds WPL = (H_ACTIVE>>S)/PPW at end of each visible line whose (v_cnt+1) mod 2^S == 0.
  - Stage 1 registers mem_addr = row_base + (h_cnt >> (S+log2 PPW)), mod 2^ADDR_W (wraps, no error).
  - mem_rd_en = vis & frame_en.
  - mem_addr holds its last value when mem_rd_en=0.
- Lane select: lane = (h_cnt>>S) mod PPW, pipelined alongside the read. Lane 0 = mem_rdata[7:0], lane k = bits [8k+7:8k].
- Output stage: registered at stage L = MEM_LAT+2.
  - RGB = selected byte if vis&frame_en, else 0.
  - active = vis. h_sync = hs^~SYNC_POL. v_sync = vs^~SYNC_POL.
  - frame_start = stage-0 (h_cnt=0 && v_cnt=0) delayed L.
  - All outputs share the same latency L relative to the counters.
- With frame_en=0: sync, active and frame_start still run normally; RGB=0; no RAM reads.
- Reset mid-line: outputs go to reset values immediately, without a clock edge. Scanning restarts at (0,0) on the first edge after release.

Test Plan:
- Defaults, enable=0, reset released at cycle 0 -> h_sync low for cycles 659..754, period 800. v_sync low during lines 490-491 (1600 clocks). frame_start every 420000 clocks. RGB=0 and mem_rd_en=0 throughout.
- enable=1, base_addr=0, RAM returns data=address:
  - line 0: mem_addr steps 0..79, each held 8 clocks; pixel pattern per word w = 4 clocks w[7:0], then 4 clocks w[15:8] (e.g. word 1 -> 0x01 x4, 0x00 x4).
  - lines 1-3 repeat the same addresses; line 4 starts at 80; last fetch of the frame is 9599.
- base_addr=9600 -> frame's first address 9600, last address (9600+9599) mod 16384 = 2815; wrap is seamless.
- enable dropped at line 100 -> current frame completes with reads; next frame has mem_rd_en=0 and RGB=0 while syncs continue. base_addr changed mid-frame -> applied only at next frame_start.
- rst_n pulsed low mid-line 200 (no clock edge) -> all outputs at reset values immediately. After release, first h_sync assertion at cycle 659 and first frame_start at cycle L=3.
- Small timing (H 8/2/2/2, V 4/1/1/1, SCALE_LOG2=0, MEM_LAT=3) -> mem_addr increments every 2 clocks, 4 words/line, 16 words/frame. Outputs lag counters by 5 clocks. Line period 14, frame period 98.

Source files
------------

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout
// VGA scan-out engine: raster timing, framebuffer address generation and
// pixel unpacking in one block. Each source pixel is replicated
// 2^SCALE_LOG2 times in x and y and driven out as RGB332.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   enable       scan-out enable, taken at frame start
//   base_addr    framebuffer word base, taken at frame start
//   mem_addr     RAM read address
//   mem_rd_en    RAM read strobe
//   mem_rdata    RAM read data, valid MEM_LAT clocks after mem_addr
//   vga_red      pixel bits [7:5]
//   vga_green    pixel bits [4:2]
//   vga_blue     pixel bits [1:0]
//   h_sync       horizontal sync (active level SYNC_POL)
//   v_sync       vertical sync (active level SYNC_POL)
//   active       displayed pixel is inside the visible area
//   frame_start  one-cycle pulse with pixel (0,0) on the outputs
module vga_fb_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SCALE_LOG2 = 2,
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 14,
    parameter int MEM_LAT    = 1,
    parameter int SYNC_POL   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [2:0]        vga_red,
    output logic [2:0]        vga_green,
    output logic [1:0]        vga_blue,
    output logic              h_sync,
    output logic              v_sync,
    output logic              active,
    output logic              frame_start
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW        = $clog2(H_TOTAL);
    localparam int VW        = $clog2(V_TOTAL);
    localparam int PPW       = WORD_W / 8;
    localparam int PW        = $clog2(PPW);
    localparam int LANE_W    = (PW > 0) ? PW : 1;
    localparam int COL_SHIFT = SCALE_LOG2 + PW;
    localparam int D         = MEM_LAT + 1;

    localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_VIS    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]     H_SS     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_VIS    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     V_SS     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0]     V_MASK   = VW'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] WPL      = ADDR_W'((H_ACTIVE >> SCALE_LOG2) / PPW);
    localparam logic [LANE_W-1:0] LANE_MSK = LANE_W'(PPW - 1);
    localparam logic              SYNC_ACT = (SYNC_POL != 0);

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic              vis0, hs0, vs0, fs0, en0, line_done;
    logic [ADDR_W-1:0] row_base, row_eff, next_addr;
    logic [LANE_W-1:0] lane0;
    logic              frame_en;

    logic [D-1:0]      vis_p, hs_p, vs_p, fs_p, en_p;
    logic [LANE_W-1:0] lane_p [D];
    logic [7:0]        pix;

    // Stage-0 decode of the raster position. At the first pixel of a frame
    // the registered frame settings are not yet updated, so the live enable
    // and base are used directly; that keeps pixel (0,0) consistent with the
    // rest of the frame it belongs to.
    always_comb begin
        vis0      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs0       = (h_cnt >= H_SS) && (h_cnt <= H_SE);
        vs0       = (v_cnt >= V_SS) && (v_cnt <= V_SE);
        fs0       = (h_cnt == '0) && (v_cnt == '0);
        en0       = vis0 && (fs0 ? enable : frame_en);
        row_eff   = fs0 ? base_addr : row_base;
        next_addr = row_eff + ADDR_W'(h_cnt >> COL_SHIFT);
        lane0     = LANE_W'(h_cnt >> SCALE_LOG2) & LANE_MSK;
        line_done = (h_cnt == H_LAST) && (v_cnt < V_VIS) &&
                    ((v_cnt & V_MASK) == V_MASK);
    end

    // Raster counters: h_cnt wraps at the end of every line and v_cnt
    // advances on each wrap, itself wrapping at the end of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Frame settings and row base. row_base is loaded with the frame's base
    // at frame start and doubles as the latched base for the frame; it then
    // steps by one source line of words after the last replicated copy of
    // each source line, so no multiplier is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_en <= 1'b0;
            row_base <= '0;
        end else if (fs0) begin
            frame_en <= enable;
            row_base <= base_addr;
        end else if (line_done) begin
            row_base <= row_base + WPL;
        end
    end

    // Stage 1: RAM request. The address only moves on real reads so the RAM
    // sees a stable address while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
        end else begin
            mem_rd_en <= en0;
            if (en0) begin
                mem_addr <= next_addr;
            end
        end
    end

    // Side-band pipeline that carries the decode results alongside the RAM
    // read so they line up with mem_rdata at the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vis_p <= '0;
            hs_p  <= '0;
            vs_p  <= '0;
            fs_p  <= '0;
            en_p  <= '0;
            for (int i = 0; i < D; i++) begin
                lane_p[i] <= '0;
            end
        end else begin
            vis_p     <= {vis_p[D-2:0], vis0};
            hs_p      <= {hs_p[D-2:0], hs0};
            vs_p      <= {vs_p[D-2:0], vs0};
            fs_p      <= {fs_p[D-2:0], fs0};
            en_p      <= {en_p[D-2:0], en0};
            lane_p[0] <= lane0;
            for (int i = 1; i < D; i++) begin
                lane_p[i] <= lane_p[i-1];
            end
        end
    end

    // Pick the byte of the returned word that holds the current pixel.
    always_comb begin
        pix = '0;
        for (int k = 0; k < PPW; k++) begin
            if (lane_p[D-1] == LANE_W'(k)) begin
                pix = mem_rdata[8*k +: 8];
            end
        end
    end

    // Output register: every pad output leaves here so all of them share
    // the same latency behind the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_red     <= '0;
            vga_green   <= '0;
            vga_blue    <= '0;
            active      <= 1'b0;
            h_sync      <= ~SYNC_ACT;
            v_sync      <= ~SYNC_ACT;
            frame_start <= 1'b0;
        end else begin
            vga_red     <= en_p[D-1] ? pix[7:5] : 3'd0;
            vga_green   <= en_p[D-1] ? pix[4:2] : 3'd0;
            vga_blue    <= en_p[D-1] ? pix[1:0] : 2'd0;
            active      <= vis_p[D-1];
            h_sync      <= hs_p[D-1] ? SYNC_ACT : ~SYNC_ACT;
            v_sync      <= vs_p[D-1] ? SYNC_ACT : ~SYNC_ACT;
            frame_start <= fs_p[D-1];
        end
    end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout
// Directed bench for vga_fb_scanout on a small raster (16x8 visible,
// 22x11 total, 2x replication, two pixels per word, 32-word RAM, read
// latency 2). The RAM returns a word derived from its address so every
// displayed pixel identifies the word and lane it came from.
module tb_vga_fb_scanout;

    localparam int HA = 16, HFP = 2, HS = 2, HBP = 2;
    localparam int VA = 8,  VFP = 1, VS = 1, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int LAT = 2;
    localparam int L = LAT + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [4:0]  base_addr = '0;
    logic [4:0]  mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rdata = '0;
    logic [2:0]  vga_red, vga_green;
    logic [1:0]  vga_blue;
    logic        h_sync, v_sync, active, frame_start;

    logic [4:0]  ram_s1 = '0;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    logic       en_hist   [8];
    logic [4:0] base_hist [8];
    int         rd_count  [8];
    int         first_rd  [8];
    int         last_rd   [8];
    int         first_hs, first_fs, fs_count;
    logic [4:0] exp_hold;

    vga_fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SCALE_LOG2(1), .WORD_W(16), .ADDR_W(5), .MEM_LAT(LAT), .SYNC_POL(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .base_addr(base_addr),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .h_sync(h_sync), .v_sync(v_sync), .active(active),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ram_word(input logic [4:0] a);
        return {a, 3'b110, a, 3'b001};
    endfunction

    // Two-cycle read latency RAM model.
    always @(posedge clk) begin
        ram_s1    <= mem_addr;
        mem_rdata <= ram_word(ram_s1);
    end

    function automatic logic model_vis(input int k);
        int r;
        r = k % FRAME;
        return ((r % HT) < HA) && ((r / HT) < VA);
    endfunction

    function automatic logic [4:0] model_addr(input int k);
        int r;
        r = k % FRAME;
        return 5'(int'(base_hist[k / FRAME]) + ((r / HT) / 2) * 4 + (r % HT) / 4);
    endfunction

    // Expected {rgb, active, h_sync, v_sync, frame_start} for the pixel the
    // counters held at cycle k.
    function automatic logic [11:0] model_out(input int k);
        int r, h, v;
        logic [7:0] p;
        logic [4:0] a;
        if (k < 0) return 12'h006;
        r = k % FRAME;
        h = r % HT;
        v = r / HT;
        a = model_addr(k);
        p = (((h / 2) % 2) == 1) ? {a, 3'b110} : {a, 3'b001};
        if (!(model_vis(k) && en_hist[k / FRAME])) p = 8'h00;
        return {p, model_vis(k), !(h >= HA + HFP && h <= HA + HFP + HS - 1),
                !(v == VA + VFP), r == 0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                      tag, obs, exp, cyc);
    endtask

    task automatic clearStats();
        for (int i = 0; i < 8; i++) begin
            rd_count[i] = 0;
            first_rd[i] = -1;
            last_rd[i]  = -1;
        end
        first_hs = -1;
        first_fs = -1;
        fs_count = 0;
        exp_hold = '0;
    endtask

    task automatic checkCycle();
        int k;
        logic exp_rd;
        checkOutput("pixel_out",
            32'({vga_red, vga_green, vga_blue, active, h_sync, v_sync, frame_start}),
            32'(model_out(cyc - L)));
        k = cyc - 1;
        exp_rd = (k >= 0) && model_vis(k) && en_hist[(k < 0) ? 0 : k / FRAME];
        if (exp_rd) exp_hold = model_addr(k);
        checkOutput("rd_en", 32'(mem_rd_en), 32'(exp_rd));
        checkOutput("mem_addr", 32'(mem_addr), 32'(exp_hold));
        if (mem_rd_en === 1'b1 && k >= 0) begin
            if (rd_count[k / FRAME] == 0) first_rd[k / FRAME] = int'(mem_addr);
            last_rd[k / FRAME] = int'(mem_addr);
            rd_count[k / FRAME]++;
        end
        if (h_sync === 1'b0 && first_hs < 0) first_hs = cyc;
        if (frame_start === 1'b1) begin
            if (first_fs < 0) first_fs = cyc;
            fs_count++;
        end
    endtask

    // Runs from the current cycle up to (not including) cycle 'upto' with
    // the given inputs, checking every cycle at the falling edge.
    task automatic applyStimulus(input int upto, input logic en_v,
                                 input logic [4:0] base_v);
        enable    = en_v;
        base_addr = base_v;
        while (cyc < upto) begin
            if (cyc % FRAME == 0) begin
                en_hist[cyc / FRAME]   = enable;
                base_hist[cyc / FRAME] = base_addr;
            end
            checkCycle();
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        clearStats();
        repeat (3) @(negedge clk);
        checkOutput("reset_out",
            32'({vga_red, vga_green, vga_blue, active, h_sync, v_sync, frame_start}),
            32'h006);
        checkOutput("reset_mem", 32'({mem_rd_en, mem_addr}), 32'h0);

        rst_n = 1'b1;
        cyc = 0;
        applyStimulus(FRAME, 1'b0, 5'd0);
        applyStimulus(FRAME + 100, 1'b1, 5'd0);
        applyStimulus(2 * FRAME + 60, 1'b1, 5'd24);
        applyStimulus(3 * FRAME + 30, 1'b0, 5'd24);
        applyStimulus(4 * FRAME + 50, 1'b1, 5'd3);

        checkOutput("first_hsync", 32'(first_hs), 32'd22);
        checkOutput("first_fstart", 32'(first_fs), 32'd4);
        checkOutput("fstart_count", 32'(fs_count), 32'd5);
        checkOutput("f0_reads", 32'(rd_count[0]), 32'd0);
        checkOutput("f1_reads", 32'(rd_count[1]), 32'd128);
        checkOutput("f1_first", 32'(first_rd[1]), 32'd0);
        checkOutput("f1_last", 32'(last_rd[1]), 32'd15);
        checkOutput("f2_reads", 32'(rd_count[2]), 32'd128);
        checkOutput("f2_first", 32'(first_rd[2]), 32'd24);
        checkOutput("f2_last", 32'(last_rd[2]), 32'd7);
        checkOutput("f3_reads", 32'(rd_count[3]), 32'd0);
        checkOutput("f4_first", 32'(first_rd[4]), 32'd3);

        checkOutput("pre_rst_active", 32'(active), 32'd1);
        checkOutput("pre_rst_rd", 32'(mem_rd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out",
            32'({vga_red, vga_green, vga_blue, active, h_sync, v_sync, frame_start}),
            32'h006);
        checkOutput("async_rst_mem", 32'({mem_rd_en, mem_addr}), 32'h0);
        repeat (3) @(negedge clk);

        clearStats();
        rst_n = 1'b1;
        cyc = 0;
        applyStimulus(2 * FRAME, 1'b1, 5'd10);

        checkOutput("rst2_first_hsync", 32'(first_hs), 32'd22);
        checkOutput("rst2_first_fstart", 32'(first_fs), 32'd4);
        checkOutput("rst2_fstart_count", 32'(fs_count), 32'd2);
        checkOutput("rst2_f0_reads", 32'(rd_count[0]), 32'd128);
        checkOutput("rst2_f0_first", 32'(first_rd[0]), 32'd10);
        checkOutput("rst2_f0_last", 32'(last_rd[0]), 32'd25);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
